trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap sequencer and access arbiter for the CSR file. It sits between the execute stage and the single-port CSR file (MIP/MIE/MSTATUS/MCAUSE/MTVEC/MEPC). On an exception, ecall, enabled interrupt or mret, it stalls and flushes the pipeline and performs the required CSR writes one per cycle. It then reads the target from MTVEC or MEPC and issues a PC redirect. When idle, it passes pipeline CSR instruction accesses straight through to the CSR file.

## Interface
Parameters: none; XLEN fixed at 32.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pipe_csr_wr  in  1  pipeline CSR write request
- pipe_csr_rd  in  1  pipeline CSR read request
- pipe_csr_addr  in  12  pipeline CSR address
- pipe_csr_wdata  in  32  pipeline CSR write data
- pipe_csr_rdata  out  32  read data to pipeline
- cur_pc  in  32  PC of the instruction in execute
- exc_valid  in  1  exception for the instruction in execute
- exc_illegal  in  1  with exc_valid: 1 = illegal instruction, 0 = ecall
- mret_valid  in  1  mret in execute
- irq_ext  in  1  external interrupt, level
- irq_timer  in  1  timer interrupt, level
- csr_reg_wrpin, csr_reg_rdpin  out  1 each  CSR file write/read enables
- csr_addr32  out  32  CSR address, zero-extended from 12 bits
- csr_wdata  out  32  CSR write data
- csr_rdata  in  32  CSR read data
- stall  out  1  freeze fetch/decode/execute
- flush  out  1  kill the instruction in execute, one-cycle pulse
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  32  new fetch PC
- busy  out  1  state != IDLE

## Operation
- States: IDLE, T_MEPC, T_MCAUSE, T_MSTAT, T_VEC, R_MSTAT, R_EPC.

**IDLE**
- CSR port mirrors the pipeline request; pipe_csr_rdata = csr_rdata.
- Take priority: exc_valid > mret_valid > (irq_ext & MSTATUS[3] & MIE[11]) > (irq_timer & MSTATUS[3] & MIE[7]).
- On a take:
  - stall=1 and flush=1 in the same cycle.
  - The pipeline CSR write is suppressed that cycle.
  - cur_pc is latched into pc_q and the cause is latched into cause_q.
- Cause values: ext 0x8000000B, timer 0x80000007, ecall 0x0000000B, illegal 0x00000002.
- Trap takes go to T_MEPC; mret goes to R_MSTAT.

**Trap entry** (one CSR write per state, pipe_csr_rdata=0)
- T_MEPC: write MEPC = pc_q.
- T_MCAUSE: write MCAUSE = cause_q.
- T_MSTAT: write MSTATUS = shadow with bit7 (MPIE) = old bit3 (MIE), bit3 = 0.
- T_VEC: read MTVEC (rdpin=1).
  - If csr_rdata[1:0]==01 and cause_q[31]: redirect_pc = {rdata[31:2],00} + 4*cause_q[3:0].
  - Otherwise: redirect_pc = {rdata[31:2],00}.
  - Pulse redirect_valid, then go to IDLE.

**mret**
- R_MSTAT: write MSTATUS = shadow with bit3 = bit7, bit7 = 1.
- R_EPC: read MEPC, redirect_pc = {rdata[31:2],00}, pulse redirect_valid, then go to IDLE.

**Shadows**
- mstatus_sh[31:0] and mie_sh[31:0] update on every write to 0x300/0x304, from the pipeline or from the sequencer, on the same edge as the CSR file write.
- Interrupts sample irq_* only in IDLE.
- Pipeline requests are ignored while busy; the pipeline is stalled and holds them.

## Timing
- Reset values: all outputs 0, state IDLE, shadows 0, pc_q/cause_q 0.
- Reset mid-sequence: immediate return to IDLE; partial CSR writes are not undone.
- Trap latency: take in cycle T, writes at T+1..T+3, redirect at T+4. stall is high T..T+4 inclusive.
- mret latency: take in T, MSTATUS write at T+1, redirect at T+2. stall is high T..T+2.
- The next take is possible at the cycle after the redirect, earliest T+5 (trap) or T+3 (mret).
- redirect_pc and csr_* outputs are combinational from state and csr_rdata. state, pc_q, cause_q and shadows are registered.
- An interrupt and a pipeline CSR write in the same IDLE cycle: the interrupt wins, the write is dropped, and MEPC = cur_pc so the instruction re-executes.

## Structure
- trap_pkg holds:
  - CSR address constants (0x300, 0x304, 0x305, 0x341, 0x342, 0x344)
  - the four cause constants
  - MSTATUS bit indices MIE=3, MPIE=7 and MIE-register bits MEIE=11, MTIE=7
  - the state enum
- One sub-module, trap_sel: combinational priority/enable selection producing take, is_mret and cause.

## Test plan
- Passthrough: pipeline writes MTVEC=0x100, then reads 0x305 -> pipe_csr_rdata=0x100, stall never asserted.
- External irq: MSTATUS=0x8, MIE=0x800, MTVEC=0x100, cur_pc=0x40, irq_ext=1 ->
  - MEPC=0x40, MCAUSE=0x8000000B, MSTATUS=0x80
  - redirect_valid at T+4 with redirect_pc=0x100, stall high 5 cycles.
- Vectored timer: MTVEC=0x101, MIE=0x80, MSTATUS=0x8, irq_timer=1 -> redirect_pc=0x11C.
- Masked: MSTATUS=0x0 with both irqs high for 20 cycles -> no take, busy=0.
- mret: after the external-irq scenario, mret_valid=1 -> MSTATUS written 0x88, redirect_pc=0x40 at T+2.
- Priority and reset:
  - exc_valid (exc_illegal=1) with irq_ext=1 -> MCAUSE=0x2.
  - rst_n low during T_MCAUSE -> all outputs 0 immediately; the next irq restarts cleanly from T_MEPC.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer.
// Holds CSR addresses, trap cause codes, MSTATUS/MIE bit positions and
// the sequencer state type.
package trap_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam logic [31:0] CAUSE_EXT     = 32'h8000_000B;
   localparam logic [31:0] CAUSE_TIMER   = 32'h8000_0007;
   localparam logic [31:0] CAUSE_ECALL   = 32'h0000_000B;
   localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MEIE     = 11;
   localparam int MIE_MTIE     = 7;

   typedef enum logic [2:0] {
      IDLE,
      T_MEPC,
      T_MCAUSE,
      T_MSTAT,
      T_VEC,
      R_MSTAT,
      R_EPC
   } state_t;

endpackage

// File: rtl/trap_ctrl_if.sv
// Single-port CSR file bus.
//   csr_reg_wrpin / csr_reg_rdpin : write / read enables
//   csr_addr32                    : CSR address, zero-extended
//   csr_wdata / csr_rdata         : write / read data
// master = trap_ctrl, slave = CSR file.
interface trap_ctrl_if;
   logic        csr_reg_wrpin;
   logic        csr_reg_rdpin;
   logic [31:0] csr_addr32;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;

   modport master (
      output csr_reg_wrpin, csr_reg_rdpin, csr_addr32, csr_wdata,
      input  csr_rdata
   );

   modport slave (
      input  csr_reg_wrpin, csr_reg_rdpin, csr_addr32, csr_wdata,
      output csr_rdata
   );
endinterface

// File: rtl/trap_sel.sv
// Trap source selection (combinational).
// Inputs : exception/mret requests, interrupt levels and the enable bits
//          MSTATUS.MIE, MIE.MEIE, MIE.MTIE.
// Outputs: take (something is taken), is_mret, cause code for traps.
// Priority: exception > mret > external irq > timer irq.
module trap_sel
   import trap_pkg::*;
(
   input  logic        exc_valid,
   input  logic        exc_illegal,
   input  logic        mret_valid,
   input  logic        irq_ext,
   input  logic        irq_timer,
   input  logic        mstatus_mie,
   input  logic        mie_meie,
   input  logic        mie_mtie,
   output logic        take,
   output logic        is_mret,
   output logic [31:0] cause
);

   always_comb begin
      take    = 1'b0;
      is_mret = 1'b0;
      cause   = '0;
      if (exc_valid) begin
         take  = 1'b1;
         cause = exc_illegal ? CAUSE_ILLEGAL : CAUSE_ECALL;
      end else if (mret_valid) begin
         take    = 1'b1;
         is_mret = 1'b1;
      end else if (irq_ext && mstatus_mie && mie_meie) begin
         take  = 1'b1;
         cause = CAUSE_EXT;
      end else if (irq_timer && mstatus_mie && mie_mtie) begin
         take  = 1'b1;
         cause = CAUSE_TIMER;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer and CSR access arbiter.
// Ports: clk/rst_n; pipeline CSR request (pipe_csr_*); cur_pc, exc_*,
// mret_valid, irq_*; CSR file bus (csr, master); stall/flush/busy to the
// pipeline; redirect_valid/redirect_pc to fetch.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | pipeline CSR access passes through; watch for takes
// T_MEPC   | write MEPC = pc_q
// T_MCAUSE | write MCAUSE = cause_q
// T_MSTAT  | write MSTATUS with MPIE<=MIE, MIE<=0
// T_VEC    | read MTVEC, redirect to (possibly vectored) handler
// R_MSTAT  | write MSTATUS with MIE<=MPIE, MPIE<=1
// R_EPC    | read MEPC, redirect back
module trap_ctrl
   import trap_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_csr_wr,
   input  logic        pipe_csr_rd,
   input  logic [11:0] pipe_csr_addr,
   input  logic [31:0] pipe_csr_wdata,
   output logic [31:0] pipe_csr_rdata,
   input  logic [31:0] cur_pc,
   input  logic        exc_valid,
   input  logic        exc_illegal,
   input  logic        mret_valid,
   input  logic        irq_ext,
   input  logic        irq_timer,
   trap_ctrl_if.master csr,
   output logic        stall,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   state_t      state;
   logic [31:0] pc_q;
   logic [31:0] cause_q;
   logic [31:0] mstatus_sh;
   // Only the two enable bits of MIE are ever consumed.
   logic        mie_meie_sh;
   logic        mie_mtie_sh;

   logic        sel_take;
   logic        sel_mret;
   logic [31:0] sel_cause;
   logic        take_now;
   logic [31:0] mst_entry;
   logic [31:0] mst_exit;

   trap_sel u_sel (
      .exc_valid   (exc_valid),
      .exc_illegal (exc_illegal),
      .mret_valid  (mret_valid),
      .irq_ext     (irq_ext),
      .irq_timer   (irq_timer),
      .mstatus_mie (mstatus_sh[MSTATUS_MIE]),
      .mie_meie    (mie_meie_sh),
      .mie_mtie    (mie_mtie_sh),
      .take        (sel_take),
      .is_mret     (sel_mret),
      .cause       (sel_cause)
   );

   assign take_now = (state == IDLE) && sel_take;
   assign busy     = (state != IDLE);
   assign stall    = take_now || busy;
   assign flush    = take_now;

   always_comb begin
      mst_entry               = mstatus_sh;
      mst_entry[MSTATUS_MPIE] = mstatus_sh[MSTATUS_MIE];
      mst_entry[MSTATUS_MIE]  = 1'b0;
      mst_exit                = mstatus_sh;
      mst_exit[MSTATUS_MIE]   = mstatus_sh[MSTATUS_MPIE];
      mst_exit[MSTATUS_MPIE]  = 1'b1;
   end

   always_comb begin
      csr.csr_reg_wrpin = 1'b0;
      csr.csr_reg_rdpin = 1'b0;
      csr.csr_addr32    = '0;
      csr.csr_wdata     = '0;
      pipe_csr_rdata    = '0;
      redirect_valid    = 1'b0;
      redirect_pc       = '0;
      case (state)
         IDLE: begin
            // A take in this cycle drops the pipeline write; the flushed
            // instruction re-executes after the handler returns.
            csr.csr_reg_wrpin = pipe_csr_wr && !sel_take;
            csr.csr_reg_rdpin = pipe_csr_rd;
            csr.csr_addr32    = {20'h0, pipe_csr_addr};
            csr.csr_wdata     = pipe_csr_wdata;
            pipe_csr_rdata    = csr.csr_rdata;
         end
         T_MEPC: begin
            csr.csr_reg_wrpin = 1'b1;
            csr.csr_addr32    = {20'h0, CSR_MEPC};
            csr.csr_wdata     = pc_q;
         end
         T_MCAUSE: begin
            csr.csr_reg_wrpin = 1'b1;
            csr.csr_addr32    = {20'h0, CSR_MCAUSE};
            csr.csr_wdata     = cause_q;
         end
         T_MSTAT: begin
            csr.csr_reg_wrpin = 1'b1;
            csr.csr_addr32    = {20'h0, CSR_MSTATUS};
            csr.csr_wdata     = mst_entry;
         end
         T_VEC: begin
            csr.csr_reg_rdpin = 1'b1;
            csr.csr_addr32    = {20'h0, CSR_MTVEC};
            redirect_valid    = 1'b1;
            // Vectored mode offsets interrupts only.
            if (csr.csr_rdata[1:0] == 2'b01 && cause_q[31])
               redirect_pc = {csr.csr_rdata[31:2], 2'b00} + {26'h0, cause_q[3:0], 2'b00};
            else
               redirect_pc = {csr.csr_rdata[31:2], 2'b00};
         end
         R_MSTAT: begin
            csr.csr_reg_wrpin = 1'b1;
            csr.csr_addr32    = {20'h0, CSR_MSTATUS};
            csr.csr_wdata     = mst_exit;
         end
         R_EPC: begin
            csr.csr_reg_rdpin = 1'b1;
            csr.csr_addr32    = {20'h0, CSR_MEPC};
            redirect_valid    = 1'b1;
            redirect_pc       = {csr.csr_rdata[31:2], 2'b00};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc_q        <= '0;
         cause_q     <= '0;
         mstatus_sh  <= '0;
         mie_meie_sh <= 1'b0;
         mie_mtie_sh <= 1'b0;
      end else begin
         if (csr.csr_reg_wrpin && csr.csr_addr32 == {20'h0, CSR_MSTATUS})
            mstatus_sh <= csr.csr_wdata;
         if (csr.csr_reg_wrpin && csr.csr_addr32 == {20'h0, CSR_MIE}) begin
            mie_meie_sh <= csr.csr_wdata[MIE_MEIE];
            mie_mtie_sh <= csr.csr_wdata[MIE_MTIE];
         end
         case (state)
            IDLE: begin
               if (sel_take) begin
                  pc_q    <= cur_pc;
                  cause_q <= sel_cause;
                  state   <= sel_mret ? R_MSTAT : T_MEPC;
               end
            end
            T_MEPC:   state <= T_MCAUSE;
            T_MCAUSE: state <= T_MSTAT;
            T_MSTAT:  state <= T_VEC;
            T_VEC:    state <= IDLE;
            R_MSTAT:  state <= R_EPC;
            R_EPC:    state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pipe_csr_wr = 1'b0;
   logic        pipe_csr_rd = 1'b0;
   logic [11:0] pipe_csr_addr = '0;
   logic [31:0] pipe_csr_wdata = '0;
   logic [31:0] pipe_csr_rdata;
   logic [31:0] cur_pc = '0;
   logic        exc_valid = 1'b0;
   logic        exc_illegal = 1'b0;
   logic        mret_valid = 1'b0;
   logic        irq_ext = 1'b0;
   logic        irq_timer = 1'b0;
   logic        stall, flush, redirect_valid, busy;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   trap_ctrl_if csr ();

   trap_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pipe_csr_wr    (pipe_csr_wr),
      .pipe_csr_rd    (pipe_csr_rd),
      .pipe_csr_addr  (pipe_csr_addr),
      .pipe_csr_wdata (pipe_csr_wdata),
      .pipe_csr_rdata (pipe_csr_rdata),
      .cur_pc         (cur_pc),
      .exc_valid      (exc_valid),
      .exc_illegal    (exc_illegal),
      .mret_valid     (mret_valid),
      .irq_ext        (irq_ext),
      .irq_timer      (irq_timer),
      .csr            (csr),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy)
   );

   // CSR file (environment): written by the DUT, read asynchronously.
   logic [31:0] mem [0:4095];
   assign csr.csr_rdata = mem[csr.csr_addr32[11:0]];
   always @(posedge clk)
      if (csr.csr_reg_wrpin) mem[csr.csr_addr32[11:0]] <= csr.csr_wdata;

   // Reference model: architectural CSR contents, the controller's view of
   // MSTATUS/MIE, and a queue of per-cycle actions still owed after a take.
   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rv;
      logic [31:0] rpc;
   } step_t;

   step_t       q[$];
   step_t       s;
   logic [31:0] mm [0:4095];
   logic [31:0] sh_mst = '0;
   logic [31:0] sh_mie = '0;
   logic        e_stall, e_flush, e_busy;
   logic [31:0] e_prd, e_cause, e_mst, e_tgt, m_tvec;
   int          kind;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          stall_cnt = 0;
   int          busy_cnt = 0;
   int          t_take = 0;
   int          t_red = 0;
   logic [31:0] last_rpc = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic step_t mk(logic wr, logic rd, logic [31:0] addr,
                                logic [31:0] wdata, logic rv, logic [31:0] rpc);
      step_t r;
      r.wr = wr; r.rd = rd; r.addr = addr; r.wdata = wdata; r.rv = rv; r.rpc = rpc;
      return r;
   endfunction

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i] = '0;
         mm[i]  = '0;
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         q.delete();
         sh_mst = '0;
         sh_mie = '0;
         chk("rst_stall", {31'h0, stall}, 32'h0);
         chk("rst_flush", {31'h0, flush}, 32'h0);
         chk("rst_busy", {31'h0, busy}, 32'h0);
         chk("rst_rv", {31'h0, redirect_valid}, 32'h0);
         chk("rst_rpc", redirect_pc, 32'h0);
         chk("rst_wr", {31'h0, csr.csr_reg_wrpin}, 32'h0);
         chk("rst_rd", {31'h0, csr.csr_reg_rdpin}, 32'h0);
      end else begin
         if (q.size() > 0) begin
            s       = q.pop_front();
            e_busy  = 1'b1;
            e_stall = 1'b1;
            e_flush = 1'b0;
            e_prd   = '0;
         end else begin
            kind    = 0;
            e_cause = '0;
            if (exc_valid) begin
               kind    = 1;
               e_cause = exc_illegal ? 32'h2 : 32'hB;
            end else if (mret_valid) begin
               kind = 2;
            end else if (irq_ext && sh_mst[3] && sh_mie[11]) begin
               kind    = 1;
               e_cause = 32'h8000_000B;
            end else if (irq_timer && sh_mst[3] && sh_mie[7]) begin
               kind    = 1;
               e_cause = 32'h8000_0007;
            end
            e_busy  = 1'b0;
            e_stall = (kind != 0);
            e_flush = (kind != 0);
            e_prd   = mm[pipe_csr_addr];
            s = mk(pipe_csr_wr && kind == 0, pipe_csr_rd, {20'h0, pipe_csr_addr},
                   pipe_csr_wdata, 1'b0, 32'h0);
            if (kind == 1) begin
               e_mst  = (sh_mst & ~32'h88) | (sh_mst[3] ? 32'h80 : 32'h0);
               m_tvec = mm[12'h305];
               e_tgt  = m_tvec & ~32'h3;
               if (m_tvec[1:0] == 2'b01 && e_cause[31])
                  e_tgt = e_tgt + 4 * (e_cause & 32'hF);
               q.push_back(mk(1'b1, 1'b0, 32'h341, cur_pc, 1'b0, 32'h0));
               q.push_back(mk(1'b1, 1'b0, 32'h342, e_cause, 1'b0, 32'h0));
               q.push_back(mk(1'b1, 1'b0, 32'h300, e_mst, 1'b0, 32'h0));
               q.push_back(mk(1'b0, 1'b1, 32'h305, 32'h0, 1'b1, e_tgt));
            end else if (kind == 2) begin
               e_mst = (sh_mst & ~32'h88) | (sh_mst[7] ? 32'h8 : 32'h0) | 32'h80;
               q.push_back(mk(1'b1, 1'b0, 32'h300, e_mst, 1'b0, 32'h0));
               q.push_back(mk(1'b0, 1'b1, 32'h341, 32'h0, 1'b1, mm[12'h341] & ~32'h3));
            end
         end

         chk("stall", {31'h0, stall}, {31'h0, e_stall});
         chk("flush", {31'h0, flush}, {31'h0, e_flush});
         chk("busy", {31'h0, busy}, {31'h0, e_busy});
         chk("redirect_valid", {31'h0, redirect_valid}, {31'h0, s.rv});
         if (s.rv) chk("redirect_pc", redirect_pc, s.rpc);
         chk("csr_wr", {31'h0, csr.csr_reg_wrpin}, {31'h0, s.wr});
         chk("csr_rd", {31'h0, csr.csr_reg_rdpin}, {31'h0, s.rd});
         if (s.wr || s.rd) chk("csr_addr", csr.csr_addr32, s.addr);
         if (s.wr) chk("csr_wdata", csr.csr_wdata, s.wdata);
         chk("pipe_rdata", pipe_csr_rdata, e_prd);

         if (stall) stall_cnt++;
         if (busy) busy_cnt++;
         if (flush) t_take = cyc;
         if (redirect_valid) begin
            t_red    = cyc;
            last_rpc = redirect_pc;
         end

         if (s.wr) begin
            mm[s.addr[11:0]] = s.wdata;
            if (s.addr == 32'h300) sh_mst = s.wdata;
            if (s.addr == 32'h304) sh_mie = s.wdata;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pwrite(input logic [11:0] a, input logic [31:0] d);
      pipe_csr_wr    = 1'b1;
      pipe_csr_addr  = a;
      pipe_csr_wdata = d;
      tick();
      pipe_csr_wr    = 1'b0;
      pipe_csr_addr  = '0;
      pipe_csr_wdata = '0;
   endtask

   initial begin
      run(3);
      rst_n = 1'b1;
      run(2);

      // Passthrough
      stall_cnt = 0;
      pwrite(12'h305, 32'h100);
      pipe_csr_rd   = 1'b1;
      pipe_csr_addr = 12'h305;
      #1;
      chk("pass_rdata_lit", pipe_csr_rdata, 32'h100);
      tick();
      pipe_csr_rd   = 1'b0;
      pipe_csr_addr = '0;
      run(2);
      chk("pass_no_stall", stall_cnt, 0);

      // External interrupt
      pwrite(12'h300, 32'h8);
      pwrite(12'h304, 32'h800);
      cur_pc    = 32'h40;
      stall_cnt = 0;
      irq_ext   = 1'b1;
      tick();
      irq_ext   = 1'b0;
      run(6);
      chk("ext_mepc", mem[12'h341], 32'h40);
      chk("ext_mcause", mem[12'h342], 32'h8000_000B);
      chk("ext_mstatus", mem[12'h300], 32'h80);
      chk("ext_rpc", last_rpc, 32'h100);
      chk("ext_stall_cycles", stall_cnt, 5);
      chk("ext_latency", t_red - t_take, 4);

      // mret
      stall_cnt  = 0;
      mret_valid = 1'b1;
      tick();
      mret_valid = 1'b0;
      run(4);
      chk("mret_mstatus", mem[12'h300], 32'h88);
      chk("mret_rpc", last_rpc, 32'h40);
      chk("mret_latency", t_red - t_take, 2);
      chk("mret_stall_cycles", stall_cnt, 3);

      // Vectored timer interrupt
      pwrite(12'h305, 32'h101);
      pwrite(12'h304, 32'h80);
      pwrite(12'h300, 32'h8);
      cur_pc    = 32'h60;
      irq_timer = 1'b1;
      tick();
      irq_timer = 1'b0;
      run(6);
      chk("tmr_rpc", last_rpc, 32'h11C);
      chk("tmr_mcause", mem[12'h342], 32'h8000_0007);
      chk("tmr_mepc", mem[12'h341], 32'h60);

      // Globally masked
      pwrite(12'h300, 32'h0);
      pwrite(12'h304, 32'h880);
      busy_cnt  = 0;
      irq_ext   = 1'b1;
      irq_timer = 1'b1;
      run(20);
      irq_ext   = 1'b0;
      irq_timer = 1'b0;
      chk("masked_busy", busy_cnt, 0);

      // Exception beats interrupt
      pwrite(12'h305, 32'h100);
      pwrite(12'h304, 32'h800);
      pwrite(12'h300, 32'h8);
      cur_pc      = 32'h70;
      irq_ext     = 1'b1;
      exc_valid   = 1'b1;
      exc_illegal = 1'b1;
      tick();
      exc_valid   = 1'b0;
      exc_illegal = 1'b0;
      irq_ext     = 1'b0;
      run(6);
      chk("prio_mcause", mem[12'h342], 32'h2);
      chk("prio_mepc", mem[12'h341], 32'h70);
      chk("prio_rpc", last_rpc, 32'h100);

      // Reset in the middle of trap entry
      pwrite(12'h300, 32'h8);
      cur_pc  = 32'h80;
      irq_ext = 1'b1;
      tick();
      tick();
      chk("rst_pre_mcause_wr", {31'h0, csr.csr_reg_wrpin}, 32'h1);
      chk("rst_pre_mcause_addr", csr.csr_addr32, 32'h342);
      rst_n = 1'b0;
      #1;
      chk("rst_now_busy", {31'h0, busy}, 32'h0);
      chk("rst_now_stall", {31'h0, stall}, 32'h0);
      chk("rst_now_wr", {31'h0, csr.csr_reg_wrpin}, 32'h0);
      chk("rst_now_rd", {31'h0, csr.csr_reg_rdpin}, 32'h0);
      chk("rst_now_rv", {31'h0, redirect_valid}, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_mcause_kept", mem[12'h342], 32'h2);
      pwrite(12'h300, 32'h8);
      pwrite(12'h304, 32'h800);
      tick();
      irq_ext = 1'b0;
      run(6);
      chk("rst_restart_mepc", mem[12'h341], 32'h80);
      chk("rst_restart_mcause", mem[12'h342], 32'h8000_000B);
      chk("rst_restart_rpc", last_rpc, 32'h100);
      chk("rst_restart_latency", t_red - t_take, 4);

      run(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
